// File: rtl/clkdv_pkg.sv
// Shared definitions for the clock-divider sequencer: FSM encoding, smallest
// legal ratio and the high-phase length of a divided period.
package clkdv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Odd ratios put the extra cycle in the high phase (N=3 -> 2 high, 1 low).
  function automatic int unsigned high_len(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clkdv_phase_counter.sv
// Position counter within one divided-clock period; flags the last cycle of the
// period and the cycle whose successor starts the low phase.
module clkdv_phase_counter
  import clkdv_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] n,
  output logic [DIV_W-1:0] cnt,
  output logic             at_boundary,
  output logic             at_fall
);

  logic [DIV_W-1:0] high;
  logic [DIV_W-1:0] cnt_inc;

  assign high        = DIV_W'(high_len(32'(n)));
  assign cnt_inc     = cnt + DIV_W'(1);
  assign at_boundary = (cnt == n - DIV_W'(1));
  assign at_fall     = (cnt_inc == high);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/clkdv_sequencer.sv
// Run-time controller for the system clock divider: generates CLKDV with a
// programmable ratio, starting, stopping and re-ratioing only on period boundaries.
module clkdv_sequencer
  import clkdv_pkg::*;
#(
  parameter int          DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 14
) (
  input  logic             CLKIN,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIV_REQ,
  input  logic [DIV_W-1:0] DIV_VAL,
  output logic             DIV_ACK,
  output logic             DIV_ERR,
  output logic             CLKDV,
  output logic             CLKDV_RISE,
  output logic             CLKDV_FALL,
  output logic             BUSY,
  output logic [DIV_W-1:0] CUR_DIV,
  output state_t           fsm_state,
  output logic [DIV_W-1:0] phase_cnt
);

  // Ratio handshake: DIV_REQ is a valid held high with DIV_VAL stable; it is
  // taken on an edge where the pending slot is empty and no ACK is already out,
  // and DIV_ACK (with DIV_ERR for ratios below MIN_DIV) pulses for the cycle
  // after that edge. A slot freed at a boundary is only refilled one edge later.

  state_t           state;
  state_t           state_next;
  logic             clkdv_next;
  logic             rise_next;
  logic             fall_next;
  logic             pend_valid;
  logic [DIV_W-1:0] pend_val;
  logic [DIV_W-1:0] cur_div;
  logic             req_take;
  logic             req_bad;
  logic             cnt_load;
  logic             cnt_run;
  logic             at_boundary;
  logic             at_fall;
  logic [DIV_W-1:0] cnt;

  assign cnt_run  = (state != IDLE);
  assign cnt_load = (state == IDLE) || at_boundary;

  clkdv_phase_counter #(
    .DIV_W (DIV_W)
  ) u_phase (
    .clk         (CLKIN),
    .rst         (RST),
    .load        (cnt_load),
    .run         (cnt_run),
    .n           (cur_div),
    .cnt         (cnt),
    .at_boundary (at_boundary),
    .at_fall     (at_fall)
  );

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // STOP keeps counting so a period is never cut short; EN only matters for
  // which state follows and whether the boundary starts a new period.
  always_comb begin
    state_next = state;
    clkdv_next = 1'b0;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          state_next = RUN;
          clkdv_next = 1'b1;
          rise_next  = 1'b1;
        end
      end
      RUN, STOP: begin
        if (at_boundary) begin
          state_next = EN ? RUN : IDLE;
          clkdv_next = EN;
          rise_next  = EN;
        end else begin
          state_next = EN ? RUN : STOP;
          clkdv_next = CLKDV & ~at_fall;
          fall_next  = at_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_take = DIV_REQ && !pend_valid && !DIV_ACK;
  assign req_bad  = (DIV_VAL < DIV_W'(MIN_DIV));

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      CLKDV      <= 1'b0;
      CLKDV_RISE <= 1'b0;
      CLKDV_FALL <= 1'b0;
      DIV_ACK    <= 1'b0;
      DIV_ERR    <= 1'b0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      cur_div    <= DIV_W'(DEFAULT_DIV);
    end else begin
      CLKDV      <= clkdv_next;
      CLKDV_RISE <= rise_next;
      CLKDV_FALL <= fall_next;
      DIV_ACK    <= req_take;
      DIV_ERR    <= req_take && req_bad;
      if (state != IDLE && at_boundary && pend_valid) begin
        cur_div    <= pend_val;
        pend_valid <= 1'b0;
      end
      // With the divider parked there is no period to protect, so load directly.
      if (req_take && !req_bad) begin
        if (state == IDLE) begin
          cur_div <= DIV_VAL;
        end else begin
          pend_valid <= 1'b1;
          pend_val   <= DIV_VAL;
        end
      end
    end
  end

  assign BUSY      = (state != IDLE);
  assign CUR_DIV   = cur_div;
  assign fsm_state = state;
  assign phase_cnt = cnt;

endmodule

// File: tb/tb_clkdv_sequencer.sv
// Self-checking bench for clkdv_sequencer: ratio table, handshake corner cases,
// stop/restart and reset with a pending ratio.
module tb_clkdv_sequencer;
  import clkdv_pkg::*;

  logic       CLKIN;
  logic       RST;
  logic       EN;
  logic       DIV_REQ;
  logic [7:0] DIV_VAL;
  logic       DIV_ACK;
  logic       DIV_ERR;
  logic       CLKDV;
  logic       CLKDV_RISE;
  logic       CLKDV_FALL;
  logic       BUSY;
  logic [7:0] CUR_DIV;
  state_t     fsm_state;
  logic [7:0] phase_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  clkdv_sequencer #(
    .DIV_W       (8),
    .DEFAULT_DIV (14)
  ) dut (
    .CLKIN      (CLKIN),
    .RST        (RST),
    .EN         (EN),
    .DIV_REQ    (DIV_REQ),
    .DIV_VAL    (DIV_VAL),
    .DIV_ACK    (DIV_ACK),
    .DIV_ERR    (DIV_ERR),
    .CLKDV      (CLKDV),
    .CLKDV_RISE (CLKDV_RISE),
    .CLKDV_FALL (CLKDV_FALL),
    .BUSY       (BUSY),
    .CUR_DIV    (CUR_DIV),
    .fsm_state  (fsm_state),
    .phase_cnt  (phase_cnt)
  );

  // clock / reset
  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want test done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    RST     = 1'b1;
    EN      = 1'b0;
    DIV_REQ = 1'b0;
    DIV_VAL = 8'd0;
    repeat (2) @(negedge CLKIN);
    RST = 1'b0;
  endtask

  // driver tasks
  task automatic wait_rise(input int bound);
    int k = 0;
    do begin
      @(negedge CLKIN);
      k++;
    end while (!CLKDV_RISE && k < bound);
    check("rise_seen", 32'(CLKDV_RISE), 1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    do begin
      @(negedge CLKIN);
      k++;
    end while (BUSY && k < bound);
    check("idle_reached", 32'(BUSY), 0);
    check("idle_clkdv_low", 32'(CLKDV), 0);
    @(negedge CLKIN);
  endtask

  task automatic do_req(input logic [7:0] v, output logic got_err, output int lat);
    DIV_REQ = 1'b1;
    DIV_VAL = v;
    lat = 0;
    do begin
      @(negedge CLKIN);
      lat++;
    end while (!DIV_ACK && lat < 20);
    check("ack_seen", 32'(DIV_ACK), 1);
    got_err = DIV_ERR;
    DIV_REQ = 1'b0;
    @(negedge CLKIN);
    check("ack_one_cycle", 32'({DIV_ACK, DIV_ERR}), 0);
  endtask

  // scoreboard: each completed CLKDV period pops one expected {high, low} shape
  bit          in_per  = 1'b0;
  logic        prev_dv = 1'b0;
  logic [7:0]  hi      = 8'd0;
  logic [7:0]  lo      = 8'd0;
  logic [15:0] e;

  always @(negedge CLKIN) begin
    if (RST) begin
      in_per  = 1'b0;
      prev_dv = 1'b0;
    end else begin
      if (CLKDV_RISE || CLKDV_FALL || CLKDV !== prev_dv)
        check("edge_pulse", 32'({prev_dv, CLKDV, CLKDV_RISE, CLKDV_FALL}),
              CLKDV ? 32'b0110 : 32'b1001);
      if (CLKDV_RISE || (in_per && !BUSY)) begin
        if (in_per) begin
          if (exp_q.size() == 0) begin
            check("period_unexpected", 32'({hi, lo}), 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("period_shape", 32'({hi, lo}), 32'(e));
          end
        end
        in_per = CLKDV_RISE;
        hi     = 8'd1;
        lo     = 8'd0;
      end else if (in_per) begin
        if (CLKDV) hi++;
        else lo++;
      end
      prev_dv = CLKDV;
    end
  end

  typedef struct {
    logic [7:0] n;
    logic       bad_n;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_cur;
  logic       got_err;
  int         lat;

  initial begin
    vecs[0] = '{8'd2,   1'b0, 8'd1,   8'd1};
    vecs[1] = '{8'd3,   1'b0, 8'd2,   8'd1};
    vecs[2] = '{8'd5,   1'b0, 8'd3,   8'd2};
    vecs[3] = '{8'd1,   1'b1, 8'd0,   8'd0};
    vecs[4] = '{8'd0,   1'b1, 8'd0,   8'd0};
    vecs[5] = '{8'd255, 1'b0, 8'd128, 8'd127};
    vecs[6] = '{8'd8,   1'b0, 8'd4,   8'd4};
    vecs[7] = '{8'd14,  1'b0, 8'd7,   8'd7};

    // reset state and default ratio 14
    RST = 1'b1; EN = 1'b0; DIV_REQ = 1'b0; DIV_VAL = 8'd0;
    repeat (2) @(negedge CLKIN);
    check("rst_bits", 32'({CLKDV, CLKDV_RISE, CLKDV_FALL, DIV_ACK, DIV_ERR, BUSY}), 0);
    check("rst_cur_div", 32'(CUR_DIV), 14);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    RST = 1'b0;
    exp_cur = 8'd14;
    repeat (3) exp_q.push_back({8'd7, 8'd7});
    EN = 1'b1;
    wait_rise(4);
    check("busy_run", 32'(BUSY), 1);
    repeat (28) @(negedge CLKIN);
    EN = 1'b0;
    wait_idle(40);
    check("default_drained", exp_q.size(), 0);

    // ratio table, each ratio loaded while idle then run for three periods
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].n, got_err, lat);
      check("req_err", 32'(got_err), 32'(vecs[i].bad_n));
      check("req_latency", lat, 1);
      if (!vecs[i].bad_n) exp_cur = vecs[i].n;
      check("table_cur_div", 32'(CUR_DIV), 32'(exp_cur));
      if (!vecs[i].bad_n) begin
        repeat (3) exp_q.push_back({vecs[i].hi, vecs[i].lo});
        EN = 1'b1;
        wait_rise(4);
        repeat (2 * int'(vecs[i].n)) @(negedge CLKIN);
        EN = 1'b0;
        wait_idle(300);
        check("table_drained", exp_q.size(), 0);
      end
    end

    // request mid-period, second request stalled, then stop and restart
    reset_dut();
    exp_q.push_back({8'd7, 8'd7});
    exp_q.push_back({8'd3, 8'd2});
    exp_q.push_back({8'd2, 8'd1});
    exp_q.push_back({8'd2, 8'd1});
    EN = 1'b1;
    wait_rise(4);
    repeat (3) @(negedge CLKIN);
    check("cnt_at_req", 32'(phase_cnt), 3);
    DIV_REQ = 1'b1;
    DIV_VAL = 8'd5;
    @(negedge CLKIN);
    check("mid_ack", 32'({DIV_ACK, DIV_ERR}), 32'b10);
    check("mid_cur_held", 32'(CUR_DIV), 14);
    DIV_VAL = 8'd3;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLKIN);
      check("stall_no_ack", 32'(DIV_ACK), 0);
    end
    @(negedge CLKIN);
    check("free_edge_no_bypass", 32'(DIV_ACK), 0);
    check("boundary_cur_5", 32'(CUR_DIV), 5);
    @(negedge CLKIN);
    check("bubble_ack", 32'({DIV_ACK, DIV_ERR}), 32'b10);
    check("bubble_cur", 32'(CUR_DIV), 5);
    DIV_REQ = 1'b0;
    repeat (4) @(negedge CLKIN);
    check("boundary_cur_3", 32'(CUR_DIV), 3);
    EN = 1'b0;
    @(negedge CLKIN);
    check("stop_state", 32'({BUSY, fsm_state}), 32'({1'b1, STOP}));
    EN = 1'b1;
    @(negedge CLKIN);
    check("restart_state", 32'(fsm_state), 32'(RUN));
    @(negedge CLKIN);
    EN = 1'b0;
    wait_idle(40);
    check("seq_drained", exp_q.size(), 0);

    // reset in the high phase with a ratio pending and another request in flight
    reset_dut();
    EN = 1'b1;
    wait_rise(4);
    DIV_REQ = 1'b1;
    DIV_VAL = 8'd5;
    @(negedge CLKIN);
    check("pend_ack", 32'(DIV_ACK), 1);
    DIV_VAL = 8'd9;
    @(negedge CLKIN);
    check("pre_rst_high", 32'(CLKDV), 1);
    RST = 1'b1;
    @(negedge CLKIN);
    check("rst_mid_bits", 32'({CLKDV, CLKDV_RISE, CLKDV_FALL, DIV_ACK, DIV_ERR, BUSY}), 0);
    check("rst_mid_cur", 32'(CUR_DIV), 14);
    RST = 1'b0;
    DIV_REQ = 1'b0;
    EN = 1'b0;
    @(negedge CLKIN);
    check("rst_no_late_ack", 32'({DIV_ACK, BUSY}), 0);
    repeat (2) exp_q.push_back({8'd7, 8'd7});
    EN = 1'b1;
    wait_rise(4);
    repeat (15) @(negedge CLKIN);
    EN = 1'b0;
    wait_idle(40);
    check("rst_pending_dropped", exp_q.size(), 0);
    check("final_cur", 32'(CUR_DIV), 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
